// File: rtl/ahb_si_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : ahb_si_arbiter
// Brief    : per-slave-interface AHB arbiter (fixed priority / round-robin),
//            burst- and lock-aware, with address- and data-phase mux selects
// Revision : 1.0
// =============================================================================
module ahb_si_arbiter #(
  parameter  int MASTER_NUM     = 4,
  parameter  int ARB_RR         = 1,
  parameter  int DEFAULT_MASTER = 0,
  localparam int IDX_W          = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [MASTER_NUM-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MASTER_NUM-1:0] addr_sel,
  output logic [MASTER_NUM-1:0] data_sel,
  output logic [IDX_W-1:0]      hmaster,
  output logic                  hmastlock
);

  localparam logic [1:0] C_TR_IDLE   = 2'b00;
  localparam logic [1:0] C_TR_BUSY   = 2'b01;
  localparam logic [1:0] C_TR_NONSEQ = 2'b10;
  localparam logic [1:0] C_TR_SEQ    = 2'b11;

  localparam logic [2:0] C_HB_INCR   = 3'b001;
  localparam logic [2:0] C_HB_WRAP4  = 3'b010;
  localparam logic [2:0] C_HB_INCR4  = 3'b011;
  localparam logic [2:0] C_HB_WRAP8  = 3'b100;
  localparam logic [2:0] C_HB_INCR8  = 3'b101;
  localparam logic [2:0] C_HB_WRAP16 = 3'b110;
  localparam logic [2:0] C_HB_INCR16 = 3'b111;

  localparam logic [IDX_W-1:0]      C_DEF_IDX    = IDX_W'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] C_DEF_ONEHOT = MASTER_NUM'(1) << DEFAULT_MASTER;

  logic [MASTER_NUM-1:0] hgrant_q,    hgrant_d;
  logic [MASTER_NUM-1:0] data_sel_q,  data_sel_d;
  logic [IDX_W-1:0]      hmaster_q,   hmaster_d;
  logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic                  hmastlock_q, hmastlock_d;
  logic [3:0]            cnt_q,       cnt_d;

  logic [IDX_W-1:0]      win_idx;
  logic                  owner_req;
  logic                  owner_lock;
  logic                  lock_ok;
  logic                  incr_ok;
  logic                  sw;

  // Remaining SEQ beats of a fixed-length burst; only accepted transfers count.
  always_comb begin
    cnt_d = cnt_q;
    if (hready) begin
      unique case (htrans)
        C_TR_NONSEQ: begin
          unique case (hburst)
            C_HB_INCR4,  C_HB_WRAP4:  cnt_d = 4'd3;
            C_HB_INCR8,  C_HB_WRAP8:  cnt_d = 4'd7;
            C_HB_INCR16, C_HB_WRAP16: cnt_d = 4'd15;
            default:                  cnt_d = 4'd0;
          endcase
        end
        C_TR_SEQ:  cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        C_TR_IDLE: cnt_d = 4'd0;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  assign owner_req  = hreq[hmaster_q];
  assign owner_lock = hlock[hmaster_q];
  assign lock_ok    = !hmastlock_q || !owner_lock;
  // An undefined-length burst ends only when its owner lets go or goes idle.
  assign incr_ok    = (hburst != C_HB_INCR) || !owner_req || (htrans == C_TR_IDLE);
  assign sw         = hready && lock_ok && (cnt_d == 4'd0) &&
                      (htrans != C_TR_BUSY) && incr_ok;

  generate
    if (ARB_RR != 0) begin : g_rr
      always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win_idx = C_DEF_IDX;
        // Search upward from the slot after the last granted requester.
        for (int k = 1; k <= MASTER_NUM; k++) begin
          idx = (int'(rr_ptr_q) + k) % MASTER_NUM;
          if (!found && hreq[IDX_W'(idx)]) begin
            win_idx = IDX_W'(idx);
            found   = 1'b1;
          end
        end
      end
    end else begin : g_fp
      always_comb begin
        win_idx = C_DEF_IDX;
        for (int k = MASTER_NUM - 1; k >= 0; k--) begin
          if (hreq[k]) begin
            win_idx = IDX_W'(k);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    hgrant_d    = hgrant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    rr_ptr_d    = rr_ptr_q;
    if (sw) begin
      hgrant_d    = MASTER_NUM'(1) << win_idx;
      hmaster_d   = win_idx;
      hmastlock_d = hlock[win_idx];
      if (hreq[win_idx]) begin
        rr_ptr_d = win_idx;
      end
    end
  end

  // Data phase follows the accepted address phase; wait states stretch it.
  always_comb begin
    data_sel_d = data_sel_q;
    if (hready) begin
      data_sel_d = ((htrans == C_TR_NONSEQ) || (htrans == C_TR_SEQ)) ?
                   hgrant_q : '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hgrant_q    <= C_DEF_ONEHOT;
      hmaster_q   <= C_DEF_IDX;
      hmastlock_q <= 1'b0;
      rr_ptr_q    <= C_DEF_IDX;
      cnt_q       <= 4'd0;
      data_sel_q  <= '0;
    end else begin
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      data_sel_q  <= data_sel_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign addr_sel  = hgrant_q;
  assign data_sel  = data_sel_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule
`default_nettype wire
